// File: rtl/jtag_shift_master.sv
// jtag_shift_master: single-TAP JTAG scan engine.
// Runs DR/IR scans and TAP resets on a divided TCK.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [2:0] {
    IDLE, PRE, SHIFT, POST, RST, DONE
  } state_e;

  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_e      state_q, state_d, nst;
  logic [7:0]  div_q, div_d;
  logic [5:0]  cnt_q, cnt_d, ncnt;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        ir_q, ir_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] rsp_q, rsp_d;
  logic        accept, tick, rise, fall;

  // TMS level for a given scan step; the TAP starts in Run-Test/Idle
  function automatic logic tms_at(state_e st, logic [5:0] c,
                                  logic ir, logic [4:0] len);
    logic v;
    v = 1'b0;
    unique case (st)
      PRE:     v = ir ? (c < 6'd2) : (c == 6'd0);
      SHIFT:   v = (c == {1'b0, len});
      POST:    v = (c == 6'd0);
      RST:     v = (c < 6'd5);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign busy      = (state_q == PRE) || (state_q == SHIFT) ||
                     (state_q == POST) || (state_q == RST);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (div_q == DIV_MAX);
  assign rise      = busy && tick && !tck_q;
  assign fall      = busy && tick && tck_q;

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

  // Next state, TCK divider, scan step sequencing and capture
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    ir_d    = ir_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    nst     = state_q;
    ncnt    = cnt_q + 6'd1;

    unique case (state_q)
      PRE: begin
        if (cnt_q == (ir_q ? 6'd3 : 6'd2)) begin
          nst  = SHIFT;
          ncnt = 6'd0;
        end
      end
      SHIFT: begin
        if (cnt_q == {1'b0, len_q}) begin
          nst  = POST;
          ncnt = 6'd0;
        end
      end
      POST: begin
        if (cnt_q == 6'd1) begin
          nst  = DONE;
          ncnt = 6'd0;
        end
      end
      RST: begin
        if (cnt_q == 6'd5) begin
          nst  = DONE;
          ncnt = 6'd0;
        end
      end
      default: begin
        nst  = state_q;
        ncnt = 6'd0;
      end
    endcase

    if (busy) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) tck_d = !tck_q;
      if (rise && state_q == SHIFT) cap_d[cnt_q[4:0]] = tdo;
      if (fall) begin
        state_d = nst;
        cnt_d   = ncnt;
        tms_d   = tms_at(nst, ncnt, ir_q, len_q);
        tdi_d   = (nst == SHIFT) ? data_q[ncnt[4:0]] : 1'b0;
        if (nst == DONE) rsp_d = (state_q == RST) ? '0 : cap_q;
      end
    end

    if (state_q == DONE) state_d = IDLE;

    if (accept) begin
      ir_d   = (cmd_op == OP_IR);
      len_d  = cmd_len;
      data_d = cmd_data;
      cap_d  = '0;
      div_d  = 8'd0;
      cnt_d  = 6'd0;
      tck_d  = 1'b0;
      tdi_d  = 1'b0;
      unique case (1'b1)
        (cmd_op == OP_NOP): state_d = DONE;
        (cmd_op == OP_RST): begin
          state_d = RST;
          tms_d   = 1'b1;
        end
        default: begin
          state_d = PRE;
          tms_d   = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset abandons any scan in flight
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      cnt_q   <= 6'd0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      ir_q    <= 1'b0;
      len_q   <= 5'd0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// tb_jtag_shift_master: scoreboard bench for jtag_shift_master.
// Directed scans against a behavioural TAP model.
module tb_jtag_shift_master;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready, rsp_valid, busy;
  logic        tck, tms, tdi, tdo;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  jtag_shift_master #(.CLK_DIV(CD)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
  } tap_e;

  tap_e        tap = TLR;
  logic [31:0] dr_sh = 32'h0;
  logic [31:0] dr_cap = 32'h3C;

  assign tdo = (tap == SHDR) ? dr_sh[0] : 1'b0;

  always @(posedge tck) begin
    if (tap == CAPDR) dr_sh <= dr_cap;
    if (tap == SHDR) dr_sh <= {tdi, dr_sh[31:1]};
    case (tap)
      TLR:   tap <= tms ? TLR : RTI;
      RTI:   tap <= tms ? SELDR : RTI;
      SELDR: tap <= tms ? SELIR : CAPDR;
      CAPDR: tap <= tms ? EX1DR : SHDR;
      SHDR:  tap <= tms ? EX1DR : SHDR;
      EX1DR: tap <= tms ? UPDR : PAUDR;
      PAUDR: tap <= tms ? EX2DR : PAUDR;
      EX2DR: tap <= tms ? UPDR : SHDR;
      UPDR:  tap <= tms ? SELDR : RTI;
      SELIR: tap <= tms ? TLR : CAPIR;
      CAPIR: tap <= tms ? EX1IR : SHIR;
      SHIR:  tap <= tms ? EX1IR : SHIR;
      EX1IR: tap <= tms ? UPIR : PAUIR;
      PAUIR: tap <= tms ? EX2IR : PAUIR;
      EX2IR: tap <= tms ? UPIR : SHIR;
      default: tap <= tms ? SELDR : RTI;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  typedef struct {
    logic [31:0] rsp;
    int          ntck;
    logic [63:0] tms_p;
    logic [63:0] tdi_p;
    int          nbusy;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;

  int          n_rise = 0;
  int          n_busy = 0;
  int          align_err = 0;
  logic [63:0] tms_log = 64'h0;
  logic [63:0] tdi_log = 64'h0;
  logic        p_tms = 1'b1;
  logic        p_tdi = 1'b0;
  logic        p_tck = 1'b0;

  // Monitor: logs the wire, pops the scoreboard on each response
  always @(negedge clk) begin
    if (!resetb) begin
      n_rise  = 0;
      n_busy  = 0;
      tms_log = 64'h0;
      tdi_log = 64'h0;
    end else begin
      if (tck && (tms != p_tms || tdi != p_tdi)) align_err++;
      if (tck && !p_tck) begin
        if (n_rise < 64) begin
          tms_log[n_rise] = tms;
          tdi_log[n_rise] = tdi;
        end
        n_rise++;
      end
      if (busy) n_busy++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: rsp_valid with no pending cmd, rsp_data %0h",
                   rsp_data);
        end else begin
          e_cur = sb.pop_front();
          chk("rsp_data", rsp_data, e_cur.rsp);
          chk("tck_count", n_rise, e_cur.ntck);
          chk("tms_seq", tms_log, e_cur.tms_p);
          chk("tdi_seq", tdi_log, e_cur.tdi_p);
          chk("busy_cycles", n_busy, e_cur.nbusy);
          chk("tap_in_rti", 64'(tap), 64'(RTI));
        end
        n_rise  = 0;
        n_busy  = 0;
        tms_log = 64'h0;
        tdi_log = 64'h0;
      end
    end
    p_tck = tck;
    p_tms = tms;
    p_tdi = tdi;
  end

  task automatic push(input logic [31:0] r, input int nt,
                      input logic [63:0] tp, input logic [63:0] dp,
                      input int nb);
    exp_t e;
    e.rsp   = r;
    e.ntck  = nt;
    e.tms_p = tp;
    e.tdi_p = dp;
    e.nbusy = nb;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] len,
                      input logic [31:0] data, input logic hold,
                      output logic rv);
    int t;
    t = 0;
    rv = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    while (!cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) fail_to("accept");
    rv = rsp_valid;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy || rsp_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_to("idle");
  endtask

  initial begin
    logic rv;
    int   t;

    repeat (3) @(negedge clk);
    chk("reset_outs", {tck, tms, tdi, cmd_ready, busy, rsp_valid, rsp_data},
        {6'b010100, 32'h0});
    resetb = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    push(32'h0, 6, 64'h1F, 64'h0, 24);
    send(2'b10, 5'd0, 32'h0, 1'b0, rv);
    wait_idle();

    dr_cap = 32'h3C;
    push(32'h3C, 13, 64'hC01, 64'h528, 52);
    send(2'b00, 5'd7, 32'hA5, 1'b0, rv);
    wait_idle();

    push(32'h0, 38, 64'h18_0000_0003, 64'hF_FFFF_FFF0, 152);
    send(2'b01, 5'd31, 32'hFFFF_FFFF, 1'b0, rv);
    wait_idle();

    dr_cap = 32'h3D;
    push(32'h1, 6, 64'h19, 64'h8, 24);
    send(2'b00, 5'd0, 32'h1, 1'b1, rv);
    push(32'h1, 6, 64'h19, 64'h0, 24);
    send(2'b00, 5'd0, 32'h0, 1'b0, rv);
    chk("b2b_accept_in_rsp", rv, 1);
    wait_idle();

    push(32'h1, 0, 64'h0, 64'h0, 0);
    send(2'b11, 5'd4, 32'hDEAD_BEEF, 1'b0, rv);
    @(negedge clk);
    chk("nop_rsp_next", rsp_valid, 1);
    chk("nop_tck_low", tck, 0);
    wait_idle();

    dr_cap = 32'h3C;
    push(32'h3C, 13, 64'hC01, 64'h78, 52);
    send(2'b00, 5'd7, 32'h0F, 1'b0, rv);
    repeat (30) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    chk("ready_low_busy", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    send(2'b00, 5'd7, 32'h0, 1'b0, rv);
    t = 0;
    while (n_rise < 7 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (n_rise < 7) fail_to("mid_shift");
    resetb = 1'b0;
    #1;
    chk("reset_mid_outs",
        {tck, tms, tdi, cmd_ready, busy, rsp_valid, rsp_data},
        {6'b010100, 32'h0});
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", cmd_ready, 1);

    push(32'h0, 6, 64'h1F, 64'h0, 24);
    send(2'b10, 5'd0, 32'h0, 1'b0, rv);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("tms_tdi_align", align_err, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
